// File: rtl/config_loader.sv
// Serial configuration loader: streams host bytes LSB-first into a logic-cluster
// configuration shift chain, optionally followed by a readback verify pass.
module config_loader #(
    parameter int unsigned CHAIN_LEN = 160,
    parameter int unsigned DIV       = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       verify,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       prog_clk,
    output logic       prog_en,
    output logic       prog_in,
    input  logic       prog_out,
    output logic       busy,
    output logic       done,
    output logic       verify_err
);

    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned DIV_W = $clog2(DIV + 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT_LO,
        SHIFT_HI,
        FINISH
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_d, bit_cnt_inc;
    logic [DIV_W-1:0] div_cnt, div_cnt_d;
    logic [2:0]       idx, idx_d;
    logic [7:0]       shift_buf, shift_buf_d;
    logic             pass_verify, pass_verify_d;
    logic             pass_verify_en, pass_verify_en_d;
    logic             prog_in_d;
    logic             verify_err_d;
    logic             div_last;
    logic             active_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_d          = state;
        bit_cnt_d        = bit_cnt;
        div_cnt_d        = div_cnt;
        idx_d            = idx;
        shift_buf_d      = shift_buf;
        pass_verify_d    = pass_verify;
        pass_verify_en_d = pass_verify_en;
        prog_in_d        = prog_in;
        verify_err_d     = verify_err;
        div_last         = (div_cnt == DIV_W'(DIV - 1));
        bit_cnt_inc      = bit_cnt + CNT_W'(1);
        active_d         = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_d          = FETCH;
                    pass_verify_en_d = verify;
                    pass_verify_d    = 1'b0;
                    bit_cnt_d        = '0;
                    verify_err_d     = 1'b0;
                end
            end
            FETCH: begin
                if (s_valid && s_ready) begin
                    shift_buf_d = s_data;
                    idx_d       = 3'd0;
                    div_cnt_d   = '0;
                    state_d     = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    state_d   = SHIFT_HI;
                    // Tail of chain must replay the bit loaded one pass earlier
                    if (pass_verify && (prog_out != prog_in)) begin
                        verify_err_d = 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt + DIV_W'(1);
                end
            end
            SHIFT_HI: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    bit_cnt_d = bit_cnt_inc;
                    idx_d     = idx + 3'd1;
                    if (bit_cnt_inc == CNT_W'(CHAIN_LEN)) begin
                        if (pass_verify_en && !pass_verify) begin
                            pass_verify_d = 1'b1;
                            bit_cnt_d     = '0;
                            state_d       = FETCH;
                        end else begin
                            state_d = FINISH;
                        end
                    end else if (idx == 3'd7) begin
                        state_d = FETCH;
                    end else begin
                        state_d = SHIFT_LO;
                    end
                end else begin
                    div_cnt_d = div_cnt + DIV_W'(1);
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // New data bit is presented together with the falling prog_clk
        if (state_d == SHIFT_LO) begin
            prog_in_d = shift_buf_d[idx_d];
        end

        active_d = (state_d == FETCH) || (state_d == SHIFT_LO) || (state_d == SHIFT_HI);
    end

    // Datapath and output flops, decoded from the next state so outputs align with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt        <= '0;
            div_cnt        <= '0;
            idx            <= '0;
            shift_buf      <= '0;
            pass_verify    <= 1'b0;
            pass_verify_en <= 1'b0;
            s_ready        <= 1'b0;
            prog_clk       <= 1'b0;
            prog_en        <= 1'b0;
            prog_in        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            verify_err     <= 1'b0;
        end else begin
            bit_cnt        <= bit_cnt_d;
            div_cnt        <= div_cnt_d;
            idx            <= idx_d;
            shift_buf      <= shift_buf_d;
            pass_verify    <= pass_verify_d;
            pass_verify_en <= pass_verify_en_d;
            s_ready        <= (state_d == FETCH);
            prog_clk       <= (state_d == SHIFT_HI);
            prog_en        <= active_d;
            prog_in        <= prog_in_d;
            busy           <= active_d;
            done           <= (state_d == FINISH);
            verify_err     <= verify_err_d;
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: a 16-bit chain instance (load scenarios)
// and a 12-bit chain instance (verify scenarios), each with a shift-register chain model.
module tb_config_loader;

    logic clk = 1'b0;
    logic rst;
    logic start_a, start_b, verify, s_valid;
    logic [7:0] s_data;
    logic a_s_ready, a_prog_clk, a_prog_en, a_prog_in, a_prog_out, a_busy, a_done, a_verify_err;
    logic b_s_ready, b_prog_clk, b_prog_en, b_prog_in, b_prog_out, b_busy, b_done, b_verify_err;
    logic sel;
    logic m_s_ready, m_prog_clk, m_prog_en, m_prog_in, m_busy, m_done, m_verify_err;
    logic [15:0] chain_a;
    logic [11:0] chain_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rises = 0;
    int dones = 0;
    bit bits[$];

    config_loader #(.CHAIN_LEN(16), .DIV(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .verify(verify),
        .s_data(s_data), .s_valid(s_valid), .s_ready(a_s_ready),
        .prog_clk(a_prog_clk), .prog_en(a_prog_en), .prog_in(a_prog_in),
        .prog_out(a_prog_out), .busy(a_busy), .done(a_done), .verify_err(a_verify_err)
    );

    config_loader #(.CHAIN_LEN(12), .DIV(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .verify(verify),
        .s_data(s_data), .s_valid(s_valid), .s_ready(b_s_ready),
        .prog_clk(b_prog_clk), .prog_en(b_prog_en), .prog_in(b_prog_in),
        .prog_out(b_prog_out), .busy(b_busy), .done(b_done), .verify_err(b_verify_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Chain models: capture on prog_clk rise, tail feeds prog_out
    always @(posedge a_prog_clk) chain_a <= {chain_a[14:0], a_prog_in};
    always @(posedge b_prog_clk) chain_b <= {chain_b[10:0], b_prog_in};
    assign a_prog_out = chain_a[15];
    assign b_prog_out = chain_b[11];

    assign m_s_ready    = sel ? b_s_ready    : a_s_ready;
    assign m_prog_clk   = sel ? b_prog_clk   : a_prog_clk;
    assign m_prog_en    = sel ? b_prog_en    : a_prog_en;
    assign m_prog_in    = sel ? b_prog_in    : a_prog_in;
    assign m_busy       = sel ? b_busy       : a_busy;
    assign m_done       = sel ? b_done       : a_done;
    assign m_verify_err = sel ? b_verify_err : a_verify_err;

    always @(posedge m_prog_clk) begin
        rises <= rises + 1;
        bits.push_back(m_prog_in);
    end

    always @(negedge clk) if (m_done) dones <= dones + 1;

    task automatic pulse_start(input logic ver);
        @(negedge clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        verify = ver;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        verify  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        s_data  = b;
        s_valid = 1'b1;
        while (m_s_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            failures++;
            $display("FAIL send_byte_timeout s_ready=%b required=1", m_s_ready);
        end
        @(negedge clk);
        acc     = cyc;
        s_valid = 1'b0;
    endtask

    task automatic wait_done(output int t);
        int n;
        n = 0;
        while (m_done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            failures++;
            $display("FAIL done_timeout done=%b required=1", m_done);
        end
        t = cyc;
    endtask

    function automatic logic [23:0] get_bits(input int start_idx, input int count);
        logic [23:0] v;
        v = '0;
        for (int i = 0; i < count; i++) begin
            if (start_idx + i < bits.size()) v[i] = bits[start_idx + i];
        end
        return v;
    endfunction

    task automatic test_reset();
        logic [6:0] got;
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0; verify = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        sel = 1'b0;
        repeat (3) @(negedge clk);
        got = {a_s_ready, a_prog_clk, a_prog_en, a_prog_in, a_busy, a_done, a_verify_err};
        checks++;
        if (got !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs_a got=%b required=0000000", got);
        end
        got = {b_s_ready, b_prog_clk, b_prog_en, b_prog_in, b_busy, b_done, b_verify_err};
        checks++;
        if (got !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs_b got=%b required=0000000", got);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_load();
        int b0, r0, acc, acc2, t;
        sel = 1'b0;
        b0 = bits.size();
        r0 = rises;
        pulse_start(1'b0);
        send_byte(8'hA5, acc);
        send_byte(8'h3C, acc2);
        wait_done(t);
        checks++;
        if (m_busy !== 1'b0) begin
            failures++;
            $display("FAIL load_busy_at_done got=%b required=0", m_busy);
        end
        checks++;
        if (t - acc != 65) begin
            failures++;
            $display("FAIL load_done_latency got=%0d required=65", t - acc);
        end
        @(negedge clk);
        checks++;
        if (m_done !== 1'b0) begin
            failures++;
            $display("FAIL load_done_width got=%b required=0", m_done);
        end
        checks++;
        if (rises - r0 != 16) begin
            failures++;
            $display("FAIL load_rises got=%0d required=16", rises - r0);
        end
        checks++;
        if (get_bits(b0, 16) !== 24'h003CA5) begin
            failures++;
            $display("FAIL load_bitstream got=%h required=003ca5", get_bits(b0, 16));
        end
        checks++;
        if (m_verify_err !== 1'b0) begin
            failures++;
            $display("FAIL load_verify_err got=%b required=0", m_verify_err);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_verify_ok();
        int b0, r0, acc, t;
        sel = 1'b1;
        b0 = bits.size();
        r0 = rises;
        pulse_start(1'b1);
        send_byte(8'hFF, acc);
        send_byte(8'h0F, acc);
        send_byte(8'hFF, acc);
        send_byte(8'h0F, acc);
        wait_done(t);
        @(negedge clk);
        checks++;
        if (rises - r0 != 24) begin
            failures++;
            $display("FAIL verify_rises got=%0d required=24", rises - r0);
        end
        checks++;
        if (get_bits(b0, 24) !== 24'hFFFFFF) begin
            failures++;
            $display("FAIL verify_bitstream got=%h required=ffffff", get_bits(b0, 24));
        end
        checks++;
        if (chain_b !== 12'hFFF) begin
            failures++;
            $display("FAIL verify_chain got=%h required=fff", chain_b);
        end
        checks++;
        if (m_verify_err !== 1'b0) begin
            failures++;
            $display("FAIL verify_ok_err got=%b required=0", m_verify_err);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_verify_err();
        int b0, r0, d0, acc, t, n;
        sel = 1'b1;
        b0 = bits.size();
        r0 = rises;
        d0 = dones;
        pulse_start(1'b1);
        send_byte(8'hFF, acc);
        send_byte(8'h0F, acc);
        send_byte(8'hFE, acc);
        n = 0;
        while (rises - r0 < 13 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (m_verify_err !== 1'b1) begin
            failures++;
            $display("FAIL verr_first_bit got=%b required=1", m_verify_err);
        end
        send_byte(8'h0F, acc);
        wait_done(t);
        @(negedge clk);
        checks++;
        if (m_verify_err !== 1'b1 || dones - d0 != 1) begin
            failures++;
            $display("FAIL verr_sticky_done got=%b/%0d required=1/1", m_verify_err, dones - d0);
        end
        checks++;
        if (get_bits(b0, 24) !== 24'hFFEFFF) begin
            failures++;
            $display("FAIL verr_bitstream got=%h required=ffefff", get_bits(b0, 24));
        end
        pulse_start(1'b0);
        checks++;
        if (m_verify_err !== 1'b0) begin
            failures++;
            $display("FAIL verr_clear_on_start got=%b required=0", m_verify_err);
        end
        send_byte(8'hFF, acc);
        send_byte(8'h0F, acc);
        wait_done(t);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_gap();
        int b0, r0, acc, t, n;
        logic gap_ok;
        sel = 1'b0;
        b0 = bits.size();
        r0 = rises;
        pulse_start(1'b0);
        send_byte(8'hA5, acc);
        n = 0;
        while (m_s_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        gap_ok = (n < 200);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_prog_clk !== 1'b0 || m_prog_en !== 1'b1) gap_ok = 1'b0;
        end
        checks++;
        if (gap_ok !== 1'b1) begin
            failures++;
            $display("FAIL gap_hold got=%b required=1 (prog_clk=%b prog_en=%b)", gap_ok, m_prog_clk, m_prog_en);
        end
        send_byte(8'h3C, acc);
        wait_done(t);
        @(negedge clk);
        checks++;
        if (rises - r0 != 16) begin
            failures++;
            $display("FAIL gap_rises got=%0d required=16", rises - r0);
        end
        checks++;
        if (get_bits(b0, 16) !== 24'h003CA5) begin
            failures++;
            $display("FAIL gap_bitstream got=%h required=003ca5", get_bits(b0, 16));
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int b0, r0, d0, acc, t, n;
        sel = 1'b0;
        r0 = rises;
        d0 = dones;
        pulse_start(1'b0);
        send_byte(8'hA5, acc);
        n = 0;
        while (rises - r0 < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({m_prog_en, m_prog_clk} !== 2'b00) begin
            failures++;
            $display("FAIL midrst_async got=%b required=00", {m_prog_en, m_prog_clk});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (dones != d0 || m_busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_no_done got=%0d/%b required=0/0", dones - d0, m_busy);
        end
        b0 = bits.size();
        r0 = rises;
        pulse_start(1'b0);
        send_byte(8'hA5, acc);
        send_byte(8'h3C, acc);
        wait_done(t);
        @(negedge clk);
        checks++;
        if (rises - r0 != 16) begin
            failures++;
            $display("FAIL midrst_reload_rises got=%0d required=16", rises - r0);
        end
        checks++;
        if (get_bits(b0, 16) !== 24'h003CA5) begin
            failures++;
            $display("FAIL midrst_reload_bits got=%h required=003ca5", get_bits(b0, 16));
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_start_busy();
        int b0, r0, d0, acc, acc2, t;
        sel = 1'b0;
        b0 = bits.size();
        r0 = rises;
        d0 = dones;
        pulse_start(1'b0);
        send_byte(8'hA5, acc);
        repeat (5) @(negedge clk);
        start_a = 1'b1;
        verify  = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        verify  = 1'b0;
        send_byte(8'h3C, acc2);
        wait_done(t);
        checks++;
        if (t - acc != 65) begin
            failures++;
            $display("FAIL busy_start_latency got=%0d required=65", t - acc);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (rises - r0 != 16) begin
            failures++;
            $display("FAIL busy_start_rises got=%0d required=16", rises - r0);
        end
        checks++;
        if (dones - d0 != 1 || m_busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_start_single_done got=%0d/%b required=1/0", dones - d0, m_busy);
        end
        checks++;
        if (get_bits(b0, 16) !== 24'h003CA5) begin
            failures++;
            $display("FAIL busy_start_bits got=%h required=003ca5", get_bits(b0, 16));
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_verify_ok();
        test_verify_err();
        test_gap();
        test_reset_mid();
        test_start_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 160, is the number of bits in the logic-cluster configuration shift chain (range 1..4095).
REQ-002 Parameter DIV, default 2, is the number of clk cycles per prog_clk half-period (range 1..255).
REQ-003 Port clk, input, 1: system clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port start, input, 1: one-cycle request to begin a configuration sequence.
REQ-006 Port verify, input, 1: sampled with start; 1 requests a load pass followed by a verify pass.
REQ-007 Port s_data, input, 8: bitstream byte.
REQ-008 Port s_valid, input, 1: s_data is valid.
REQ-009 Port s_ready, output, 1: loader accepts s_data this cycle.
REQ-010 Port prog_clk, output, 1: configuration chain shift clock.
REQ-011 Port prog_en, output, 1: configuration chain shift enable.
REQ-012 Port prog_in, output, 1: configuration chain serial data in.
REQ-013 Port prog_out, input, 1: configuration chain serial data out (tail of chain).
REQ-014 Port busy, output, 1: a sequence is in progress.
REQ-015 Port done, output, 1: one-cycle pulse when a sequence completes.
REQ-016 Port verify_err, output, 1: sticky readback mismatch flag for the last sequence.

Function
REQ-017 States: IDLE, FETCH, SHIFT_LO, SHIFT_HI, FINISH.
REQ-018 IDLE: start=1 -> FETCH; latch verify into pass_verify_en; clear bit counter, pass flag, and verify_err. start is ignored in every other state.
REQ-019 FETCH: s_ready=1; on s_valid&s_ready, load the byte into the 8-bit shift buffer, set the byte-bit index to 0, and go to SHIFT_LO. No shifting occurs while waiting (prog_clk held 0).
REQ-020 SHIFT_LO: prog_clk=0 and prog_in=buffer[index] (LSB first) for DIV cycles; then go to SHIFT_HI.
REQ-021 SHIFT_HI: prog_clk=1 for DIV cycles; the chain captures on the prog_clk rising edge. At the end: bit counter += 1 and index += 1.
REQ-022 After SHIFT_HI: if bit counter == CHAIN_LEN, end the pass; else if index == 8, go to FETCH; else go to SHIFT_LO.
REQ-023 End of pass: if pass_verify_en=1 and the current pass is the load pass, set pass=verify, clear the bit counter, discard unused buffer bits, and go to FETCH; otherwise go to FINISH.
REQ-024 Unused high bits of the final byte of each pass (CHAIN_LEN not a multiple of 8) are discarded and never shifted.
REQ-025 Verify pass: the host resends the identical bitstream. On the last clk cycle of each SHIFT_LO, prog_out is compared with prog_in; a mismatch sets verify_err (sticky until the next accepted start).
REQ-026 prog_en=1 in FETCH, SHIFT_LO and SHIFT_HI of both passes; prog_en=0 in IDLE and FINISH.
REQ-027 FINISH: done=1 for exactly one cycle, then go to IDLE; busy=0 in that cycle.
REQ-028 busy=1 in FETCH, SHIFT_LO and SHIFT_HI.
REQ-029 prog_clk, prog_en and prog_in come directly from flops (glitch-free); prog_in changes only while prog_clk=0.
REQ-030 s_ready=1 only in FETCH; s_valid outside FETCH has no effect.
REQ-031 Total prog_clk rising edges per sequence = CHAIN_LEN (load only) or 2*CHAIN_LEN (with verify).

Reset
REQ-032 While rst=1: state=IDLE, prog_clk=0, prog_en=0, prog_in=0, s_ready=0, busy=0, done=0, verify_err=0, all counters 0.
REQ-033 rst asserted mid-sequence deasserts prog_en and prog_clk immediately (asynchronously); the partial load is abandoned with no done pulse.

Verification
REQ-034 Scenario 1: CHAIN_LEN=16, DIV=2, verify=0, bytes 0xA5 then 0x3C -> prog_in sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; 16 prog_clk rises; done 1 cycle; verify_err=0.
REQ-035 Scenario 2: CHAIN_LEN=12, verify=1, bench chain model is a 12-bit shift register; send 0xFF, 0x0F twice -> 24 rises; high nibble of 0x0F never shifted; verify_err=0.
REQ-036 Scenario 3: as Scenario 2, but the second pass sends 0xFE, 0x0F -> verify_err=1 after the first verify bit; done still pulses.
REQ-037 Scenario 4: s_valid deasserted for 10 cycles between bytes -> prog_clk stays 0 and prog_en stays 1 during the gap; output bitstream unchanged.
REQ-038 Scenario 5: rst pulsed after bit 5 of 16 -> prog_en=0 and prog_clk=0 in the same cycle; no done pulse; a new start reloads from bit 0.
REQ-039 Scenario 6: start pulsed while busy -> ignored; sequence length and done timing unchanged.
